snitch_addr_split: RTL and testbench

- Splits one upstream request/response stream into NrPorts downstream targets.
- The target is selected per request by an externally decoded index (address map decode happens outside this block).
- Merges the downstream responses back onto the single upstream port in strict request order, including multi-beat responses delimited by last.
- Sits between a core/LSU request port and several memory-side targets (TCDM, peripherals, AXI bridge). It is the fan-out counterpart of snitch_demux.

---
 rtl/snitch_addr_split_pkg.sv | 16 +
 rtl/fifo_v3.sv | 52 +++++
 rtl/spill_register.sv | 51 +++++
 rtl/snitch_addr_split.sv | 107 ++++++++++
 tb/tb_snitch_addr_split.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/snitch_addr_split_pkg.sv
// Request/response payload types shared by the address-split slice.
package snitch_addr_split_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        write;
    logic [3:0]  strb;
  } dreq_t;

  typedef struct packed {
    logic [31:0] data;
    logic        error;
  } dresp_t;

endpackage

// File: rtl/fifo_v3.sv
// Synchronous FIFO used as the in-order response tracker; push on full and pop on empty are ignored.
module fifo_v3 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  localparam int unsigned AddrW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AddrW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AddrW:0]        cnt_q, cnt_d;
  logic                  do_push, do_pop;

  assign full_o  = (cnt_q == (AddrW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = (wptr_q == AddrW'(DEPTH-1)) ? '0 : wptr_q + 1'b1;
    if (do_pop)  rptr_d = (rptr_q == AddrW'(DEPTH-1)) ? '0 : rptr_q + 1'b1;
    if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      if (do_push) mem_q[wptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/spill_register.sv
// Optional one-stage cut on a valid/ready channel; Bypass turns it into plain wires.
module spill_register #(
  parameter type T      = logic,
  parameter bit  Bypass = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic valid_i,
  output logic ready_o,
  input  T     data_i,
  output logic valid_o,
  input  logic ready_i,
  output T     data_o
);

  if (Bypass) begin : gen_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_ni;
    assign valid_o = valid_i;
    assign ready_o = ready_i;
    assign data_o  = data_i;
  end else begin : gen_reg
    logic valid_q, valid_d;
    T     data_q, data_d;

    // Accept whenever the stage is empty or is being drained this cycle.
    assign ready_o = ~valid_q | ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (ready_o) begin
        valid_d = valid_i;
        if (valid_i) data_d = data_i;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else begin
        valid_q <= valid_d;
        data_q  <= data_d;
      end
    end
  end

endmodule

// File: rtl/snitch_addr_split.sv
// Fans one request stream out to NrPorts targets by an external index and
// merges the responses back in strict request order (multi-beat aware).
module snitch_addr_split
  import snitch_addr_split_pkg::*;
#(
  parameter int unsigned        NrPorts     = 2,
  parameter type                req_t       = dreq_t,
  parameter type                resp_t      = dresp_t,
  parameter int unsigned        RespDepth   = 8,
  parameter logic [NrPorts-1:0] RegisterReq = '0,
  localparam int unsigned       LogNrPorts  = (NrPorts > 1) ? $clog2(NrPorts) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  req_t                    req_payload_i,
  input  logic [LogNrPorts-1:0]   req_sel_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  output resp_t                   resp_payload_o,
  output logic                    resp_last_o,
  output logic                    resp_valid_o,
  input  logic                    resp_ready_i,
  output req_t  [NrPorts-1:0]     req_payload_o,
  output logic  [NrPorts-1:0]     req_valid_o,
  input  logic  [NrPorts-1:0]     req_ready_i,
  input  resp_t [NrPorts-1:0]     resp_payload_i,
  input  logic  [NrPorts-1:0]     resp_last_i,
  input  logic  [NrPorts-1:0]     resp_valid_i,
  output logic  [NrPorts-1:0]     resp_ready_o
);

  logic                  full, empty, push, pop, sel_ok;
  logic [LogNrPorts-1:0] head;
  logic [NrPorts-1:0]    spill_valid, spill_ready;

  if ((1 << LogNrPorts) == NrPorts) begin : gen_sel_dense
    assign sel_ok = 1'b1;
  end else begin : gen_sel_sparse
    assign sel_ok = (32'(req_sel_i) < NrPorts);
  end

  // Valid is only steered, never raised while full, so no downstream retraction.
  always_comb begin
    spill_valid = '0;
    req_ready_o = 1'b0;
    if (sel_ok) begin
      spill_valid[req_sel_i] = req_valid_i & ~full;
      req_ready_o            = spill_ready[req_sel_i] & ~full;
    end
  end

  for (genvar i = 0; i < NrPorts; i++) begin : gen_port
    spill_register #(
      .T      (req_t),
      .Bypass (~RegisterReq[i])
    ) i_spill (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .valid_i (spill_valid[i]),
      .ready_o (spill_ready[i]),
      .data_i  (req_payload_i),
      .valid_o (req_valid_o[i]),
      .ready_i (req_ready_i[i]),
      .data_o  (req_payload_o[i])
    );
  end

  always_comb begin
    resp_payload_o = resp_payload_i[head];
    resp_last_o    = resp_last_i[head];
    resp_valid_o   = 1'b0;
    resp_ready_o   = '0;
    if (!empty) begin
      resp_valid_o       = resp_valid_i[head];
      resp_ready_o[head] = resp_ready_i;
    end
  end

  assign push = req_valid_i & req_ready_o;
  assign pop  = resp_valid_o & resp_ready_i & resp_last_o;

  if (NrPorts > 1) begin : gen_order
    fifo_v3 #(
      .DATA_WIDTH (LogNrPorts),
      .DEPTH      (RespDepth)
    ) i_order_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (push),
      .data_i  (req_sel_i),
      .pop_i   (pop),
      .data_o  (head),
      .full_o  (full),
      .empty_o (empty)
    );
  end else begin : gen_single
    logic unused_handshake;
    assign unused_handshake = push ^ pop;
    assign head  = '0;
    assign full  = 1'b0;
    assign empty = 1'b0;
  end

  sel_in_range : assert property (@(posedge clk_i) disable iff (!rst_ni)
    req_valid_i |-> sel_ok);

endmodule

// File: tb/tb_snitch_addr_split.sv
// Directed bench for snitch_addr_split: 4 ports, port 1 registered, order depth 8.
module tb_snitch_addr_split;
  import snitch_addr_split_pkg::*;

  localparam int unsigned N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  dreq_t           req_payload_i;
  logic [1:0]      req_sel_i;
  logic            req_valid_i, req_ready_o;
  dresp_t          resp_payload_o;
  logic            resp_last_o, resp_valid_o, resp_ready_i;
  dreq_t  [N-1:0]  req_payload_o;
  logic   [N-1:0]  req_valid_o, req_ready_i;
  dresp_t [N-1:0]  resp_payload_i;
  logic   [N-1:0]  resp_last_i, resp_valid_i, resp_ready_o;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  snitch_addr_split #(
    .NrPorts     (4),
    .RespDepth   (8),
    .RegisterReq (4'b0010)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_payload_i  (req_payload_i),
    .req_sel_i      (req_sel_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .resp_payload_o (resp_payload_o),
    .resp_last_o    (resp_last_o),
    .resp_valid_o   (resp_valid_o),
    .resp_ready_i   (resp_ready_i),
    .req_payload_o  (req_payload_o),
    .req_valid_o    (req_valid_o),
    .req_ready_i    (req_ready_i),
    .resp_payload_i (resp_payload_i),
    .resp_last_i    (resp_last_i),
    .resp_valid_i   (resp_valid_i),
    .resp_ready_o   (resp_ready_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input logic v, input logic [1:0] s, input logic [31:0] a);
    req_valid_i        = v;
    req_sel_i          = s;
    req_payload_i      = '0;
    req_payload_i.addr = a;
  endtask

  task automatic drive_rsp(input int unsigned p, input logic v, input logic l, input logic [31:0] d);
    resp_valid_i[p]        = v;
    resp_last_i[p]         = l;
    resp_payload_i[p].data = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    drive_req(1'b0, 2'd0, 32'h0);
    resp_ready_i   = 1'b1;
    req_ready_i    = '1;
    resp_payload_i = '0;
    resp_last_i    = '0;
    resp_valid_i   = '0;

    // reset state
    #12;
    chk("rst_req_valid", req_valid_o, 4'b0000);
    chk("rst_resp_valid", resp_valid_o, 1'b0);
    chk("rst_resp_ready", resp_ready_o, 4'b0000);
    chk("rst_req_ready", req_ready_o, 1'b1);
    @(negedge clk); rst_n = 1'b1;

    // in-order merge: requests 2,0,3; responses arrive 3,0,2
    @(negedge clk); drive_req(1'b1, 2'd2, 32'hA2); #1;
    chk("ord_valid_s2", req_valid_o, 4'b0100);
    chk("ord_bcast0", req_payload_o[0].addr, 32'hA2);
    chk("ord_bcast3", req_payload_o[3].addr, 32'hA2);
    chk("ord_ready", req_ready_o, 1'b1);
    @(negedge clk); drive_req(1'b1, 2'd0, 32'hA0); #1;
    chk("ord_valid_s0", req_valid_o, 4'b0001);
    @(negedge clk); drive_req(1'b1, 2'd3, 32'hA3); #1;
    chk("ord_valid_s3", req_valid_o, 4'b1000);
    @(negedge clk); drive_req(1'b0, 2'd0, 32'h0); drive_rsp(3, 1'b1, 1'b1, 32'hD3); #1;
    chk("ord_t3_held", resp_ready_o, 4'b0100);
    chk("ord_t3_novalid", resp_valid_o, 1'b0);
    @(negedge clk); drive_rsp(0, 1'b1, 1'b1, 32'hD0); #1;
    chk("ord_t0_held", resp_ready_o, 4'b0100);
    chk("ord_t0_novalid", resp_valid_o, 1'b0);
    @(negedge clk); drive_rsp(2, 1'b1, 1'b1, 32'hD2); #1;
    chk("ord_1st_valid", resp_valid_o, 1'b1);
    chk("ord_1st_data", resp_payload_o.data, 32'hD2);
    @(negedge clk); drive_rsp(2, 1'b0, 1'b0, 32'h0); #1;
    chk("ord_2nd_data", resp_payload_o.data, 32'hD0);
    chk("ord_2nd_ready", resp_ready_o, 4'b0001);
    chk("ord_2nd_valid", resp_valid_o, 1'b1);
    @(negedge clk); drive_rsp(0, 1'b0, 1'b0, 32'h0); #1;
    chk("ord_3rd_data", resp_payload_o.data, 32'hD3);
    chk("ord_3rd_ready", resp_ready_o, 4'b1000);
    @(negedge clk); drive_rsp(3, 1'b0, 1'b0, 32'h0); resp_valid_i = '1; #1;
    chk("ord_empty_valid", resp_valid_o, 1'b0);
    chk("ord_empty_ready", resp_ready_o, 4'b0000);
    resp_valid_i = '0;

    // registered port 1, then 4-beat response
    @(negedge clk); drive_req(1'b1, 2'd1, 32'hB1); #1;
    chk("spill_ready", req_ready_o, 1'b1);
    chk("spill_not_yet", req_valid_o, 4'b0000);
    @(negedge clk); drive_req(1'b0, 2'd0, 32'h0); #1;
    chk("spill_valid", req_valid_o, 4'b0010);
    chk("spill_payload", req_payload_o[1].addr, 32'hB1);
    @(negedge clk); #1;
    chk("spill_drained", req_valid_o, 4'b0000);
    for (int unsigned b = 1; b <= 4; b++) begin
      @(negedge clk); drive_rsp(1, 1'b1, (b == 4), 32'hB0 + b); #1;
      chk("mb_valid", resp_valid_o, 1'b1);
      chk("mb_last", resp_last_o, (b == 4));
      chk("mb_data", resp_payload_o.data, 32'hB0 + b);
    end
    @(negedge clk); drive_rsp(1, 1'b1, 1'b0, 32'hBF); #1;
    chk("mb_popped_valid", resp_valid_o, 1'b0);
    chk("mb_popped_ready", resp_ready_o, 4'b0000);
    drive_rsp(1, 1'b0, 1'b0, 32'h0);

    // full: 9 requests to port 0 with no responses
    for (int unsigned i = 0; i < 9; i++) begin
      @(negedge clk); drive_req(1'b1, 2'd0, i); #1;
      chk("full_ready", req_ready_o, (i < 8));
      if (i == 8) chk("full_no_valid", req_valid_o, 4'b0000);
    end
    @(negedge clk); drive_rsp(0, 1'b1, 1'b1, 32'h55); #1;
    chk("full_no_fallthru", req_ready_o, 1'b0);
    chk("full_pop_valid", resp_valid_o, 1'b1);
    @(negedge clk); drive_rsp(0, 1'b0, 1'b0, 32'h0); #1;
    chk("full_after_pop", req_ready_o, 1'b1);
    @(negedge clk); drive_req(1'b0, 2'd0, 32'h0); #1;
    chk("full_refilled", req_ready_o, 1'b0);
    for (int unsigned i = 0; i < 8; i++) begin
      @(negedge clk); drive_rsp(0, 1'b1, 1'b1, 32'h60 + i); #1;
      chk("full_drain", resp_valid_o, 1'b1);
    end
    @(negedge clk); #1;
    chk("full_drained", resp_valid_o, 1'b0);
    drive_rsp(0, 1'b0, 1'b0, 32'h0);

    // back-pressure on port 2
    req_ready_i[2] = 1'b0;
    for (int unsigned c = 0; c < 5; c++) begin
      @(negedge clk); drive_req(1'b1, 2'd2, 32'hC2); #1;
      chk("bp_valid", req_valid_o, 4'b0100);
      chk("bp_payload", req_payload_o[2].addr, 32'hC2);
      chk("bp_no_ready", req_ready_o, 1'b0);
    end
    @(negedge clk); req_ready_i[2] = 1'b1; #1;
    chk("bp_ready", req_ready_o, 1'b1);
    @(negedge clk); drive_req(1'b0, 2'd0, 32'h0); drive_rsp(2, 1'b1, 1'b1, 32'hE2); #1;
    chk("bp_resp_valid", resp_valid_o, 1'b1);
    @(negedge clk); #1;
    chk("bp_single_push", resp_valid_o, 1'b0);
    drive_rsp(2, 1'b0, 1'b0, 32'h0);

    // reset with three requests outstanding
    req_ready_i[1] = 1'b0;
    @(negedge clk); drive_req(1'b1, 2'd0, 32'hF0);
    @(negedge clk); drive_req(1'b1, 2'd1, 32'hF1);
    @(negedge clk); drive_req(1'b1, 2'd2, 32'hF2);
    @(negedge clk); drive_req(1'b0, 2'd0, 32'h0); drive_rsp(0, 1'b1, 1'b1, 32'hE0); #1;
    chk("pre_rst_spill", req_valid_o, 4'b0010);
    chk("pre_rst_resp", resp_valid_o, 1'b1);
    #1 rst_n = 1'b0; #1;
    chk("arst_req_valid", req_valid_o, 4'b0000);
    chk("arst_resp_valid", resp_valid_o, 1'b0);
    chk("arst_resp_ready", resp_ready_o, 4'b0000);
    @(negedge clk); rst_n = 1'b1; req_ready_i = '1; drive_rsp(0, 1'b0, 1'b0, 32'h0);
    @(negedge clk); drive_req(1'b1, 2'd0, 32'hF8); drive_rsp(0, 1'b1, 1'b1, 32'hE8); #1;
    chk("post_valid", req_valid_o, 4'b0001);
    chk("post_ready", req_ready_o, 1'b1);
    chk("post_no_bypass", resp_valid_o, 1'b0);
    @(negedge clk); drive_req(1'b0, 2'd0, 32'h0); #1;
    chk("post_resp_valid", resp_valid_o, 1'b1);
    chk("post_resp_data", resp_payload_o.data, 32'hE8);
    @(negedge clk); #1;
    chk("post_empty", resp_valid_o, 1'b0);
    drive_rsp(0, 1'b0, 1'b0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
